// File: rtl/osc_freq_detect.sv
// osc_freq_detect
//
// Pitch detector for the sample path. Watches a stream of signed 16-bit
// samples, measures the number of sample beats between rising zero crossings
// and converts that period to a 12-bit frequency in Hz (SAMPLE_RATE / period,
// truncated, saturated at 4095) with a restoring divider that produces one
// quotient bit per clock.
//
// Optional feature macro: OSC_FREQ_HYST_EN
//   defined   - a crossing must be preceded by a sample below -THRESH (armed)
//   undefined - crossings use the sign test only, THRESH is unused
//
// Ports
//   clk          in   single clock, all logic on posedge
//   rst_n        in   synchronous active-low reset
//   sample_valid in   one-cycle strobe qualifying sample
//   sample       in   16-bit two's-complement audio sample
//   freq         out  last measured frequency in Hz (0 while no signal)
//   freq_valid   out  one-cycle pulse when freq updates from a measurement
//   no_signal    out  high while no valid measurement is held
//   busy         out  divider running
module osc_freq_detect #(
   parameter int SAMPLE_RATE = 48000,
   parameter int MAX_PERIOD  = 4095,
   parameter int THRESH      = 1024
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        sample_valid,
   input  logic [15:0] sample,
   output logic [11:0] freq,
   output logic        freq_valid,
   output logic        no_signal,
   output logic        busy
);

   localparam logic [23:0] DIVIDEND    = 24'(SAMPLE_RATE);
   localparam logic [15:0] TIMEOUT_CNT = 16'(MAX_PERIOD - 1);
   // Out-of-range parameters would silently truncate the dividend, counter
   // limit or threshold; such a build never reports a crossing.
   localparam logic CFG_OK = (SAMPLE_RATE < 2**24) && (MAX_PERIOD < 2**16) &&
                             (MAX_PERIOD >= 2) && (THRESH >= 0) && (THRESH < 2**15);

   typedef enum logic [0:0] {
      SEEK  = 1'b0,
      COUNT = 1'b1
   } state_t;

   state_t      state_r, state_s;
   logic        prev_sign_r;
   logic [15:0] cnt_r;
   logic [15:0] divisor_r;
   logic [16:0] rem_r;
   logic [23:0] quot_r;
   logic [4:0]  iter_r;
   logic        busy_r;
   logic [11:0] freq_r;
   logic        freq_valid_r;
   logic        no_signal_r;

   logic        crossing_s;
   logic        start_s;
   logic        timeout_s;
   logic [16:0] rem_shift_s;
   logic [16:0] diff_s;
   logic [16:0] rem_next_s;
   logic [23:0] quot_next_s;

   // Quotient above the 12-bit range reads as the top code.
   function automatic logic [11:0] sat12(input logic [23:0] q);
      logic [11:0] r;
      if (q[23:12] != 12'd0) begin
         r = 12'hFFF;
      end else begin
         r = q[11:0];
      end
      return r;
   endfunction

`ifdef OSC_FREQ_HYST_EN
   localparam logic signed [16:0] NEG_THRESH = -(17'(THRESH));
   logic armed_r;
   logic below_s;

   // Sign-extended compare so -32768 and THRESH near 2^15 do not wrap.
   assign below_s    = $signed({sample[15], sample}) < NEG_THRESH;
   assign crossing_s = CFG_OK & sample_valid & prev_sign_r & ~sample[15] & armed_r;

   // Arming flag: set by a clearly negative beat, consumed by the crossing.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         armed_r <= 1'b0;
      end else if (crossing_s) begin
         armed_r <= 1'b0;
      end else if (sample_valid && below_s) begin
         armed_r <= 1'b1;
      end else begin
         armed_r <= armed_r;
      end
   end
`else
   assign crossing_s = CFG_OK & sample_valid & prev_sign_r & ~sample[15];
`endif

   // Control FSM next state plus start/timeout strobes for the datapath.
   always_comb begin
      state_s   = state_r;
      start_s   = 1'b0;
      timeout_s = 1'b0;
      case (state_r)
         SEEK: begin
            if (crossing_s) begin
               state_s = COUNT;
            end else begin
               state_s = SEEK;
            end
         end
         COUNT: begin
            // A crossing wins over a timeout on the same beat; a crossing
            // while the divider is busy is dropped.
            if (crossing_s) begin
               start_s = ~busy_r;
               state_s = COUNT;
            end else if (sample_valid && (cnt_r == TIMEOUT_CNT)) begin
               timeout_s = 1'b1;
               state_s   = SEEK;
            end else begin
               state_s = COUNT;
            end
         end
         default: begin
            state_s = SEEK;
         end
      endcase
   end

   // One restoring-division step: shift in the next dividend bit, subtract
   // the divisor and keep the difference when it is non-negative.
   always_comb begin
      rem_shift_s = {rem_r[15:0], quot_r[23]};
      diff_s      = rem_shift_s - {1'b0, divisor_r};
      if (diff_s[16]) begin
         rem_next_s = rem_shift_s;
      end else begin
         rem_next_s = diff_s;
      end
      quot_next_s = {quot_r[22:0], ~diff_s[16]};
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= SEEK;
      end else begin
         state_r <= state_s;
      end
   end

   // Previous sign and beat counter, both advanced only on sample beats.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         prev_sign_r <= 1'b0;
         cnt_r       <= 16'd0;
      end else if (sample_valid) begin
         prev_sign_r <= sample[15];
         if (crossing_s || timeout_s) begin
            cnt_r <= 16'd0;
         end else begin
            cnt_r <= cnt_r + 16'd1;
         end
      end else begin
         prev_sign_r <= prev_sign_r;
         cnt_r       <= cnt_r;
      end
   end

   // Divider sequencing and the registered outputs it feeds.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         divisor_r    <= 16'd0;
         rem_r        <= 17'd0;
         quot_r       <= 24'd0;
         iter_r       <= 5'd0;
         busy_r       <= 1'b0;
         freq_r       <= 12'd0;
         freq_valid_r <= 1'b0;
         no_signal_r  <= 1'b1;
      end else begin
         freq_valid_r <= 1'b0;
         if (timeout_s) begin
            // Loss of signal: abort any divide without a pulse.
            busy_r      <= 1'b0;
            freq_r      <= 12'd0;
            no_signal_r <= 1'b1;
         end else if (start_s) begin
            // period = cnt + 1 because the crossing beat itself is counted.
            divisor_r <= cnt_r + 16'd1;
            rem_r     <= 17'd0;
            quot_r    <= DIVIDEND;
            iter_r    <= 5'd23;
            busy_r    <= 1'b1;
         end else if (busy_r) begin
            rem_r  <= rem_next_s;
            quot_r <= quot_next_s;
            if (iter_r == 5'd0) begin
               busy_r       <= 1'b0;
               freq_r       <= sat12(quot_next_s);
               freq_valid_r <= 1'b1;
               no_signal_r  <= 1'b0;
            end else begin
               iter_r <= iter_r - 5'd1;
            end
         end else begin
            busy_r <= 1'b0;
         end
      end
   end

   assign freq       = freq_r;
   assign freq_valid = freq_valid_r;
   assign no_signal  = no_signal_r;
   assign busy       = busy_r;

endmodule

// File: tb/tb_osc_freq_detect.sv
// Directed testbench for osc_freq_detect. One task per scenario, each doing
// its own comparisons against hand-computed values; a passive monitor only
// counts freq_valid pulses and records the frequency each one carried.
module tb_osc_freq_detect;

   logic        clk;
   logic        rst_n;
   logic        sample_valid;
   logic [15:0] sample;
   logic [11:0] freq;
   logic        freq_valid;
   logic        no_signal;
   logic        busy;

   int n_pass  = 0;
   int n_total = 0;
   int pulse_cnt = 0;
   logic [11:0] freq_q[$];

   osc_freq_detect #(
      .SAMPLE_RATE(48000),
      .MAX_PERIOD (4095),
      .THRESH     (1024)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .sample_valid(sample_valid),
      .sample      (sample),
      .freq        (freq),
      .freq_valid  (freq_valid),
      .no_signal   (no_signal),
      .busy        (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Pulse monitor, sampled on the falling edge.
   always @(negedge clk) begin
      if (freq_valid === 1'b1) begin
         pulse_cnt = pulse_cnt + 1;
         freq_q.push_back(freq);
      end
   end

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      sample_valid = 1'b0;
      sample = 16'd0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      pulse_cnt = 0;
      freq_q.delete();
   endtask

   // One sample beat, sampled at the next rising edge.
   task automatic beat(input logic [15:0] v);
      @(negedge clk);
      sample = v;
      sample_valid = 1'b1;
   endtask

   task automatic beats(input logic [15:0] v, input int n);
      for (int i = 0; i < n; i++) beat(v);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         sample_valid = 1'b0;
      end
   endtask

   // Square wave: 50 beats of +amp then 50 of -amp, reps times.
   task automatic square(input int amp, input int reps);
      for (int r = 0; r < reps; r++) begin
         beats(16'(amp), 50);
         beats(16'(-amp), 50);
      end
   endtask

   task automatic test_reset();
      do_reset();
      idle(1);
      n_total++; if (freq !== 12'd0) $display("FAIL reset_freq: got %0d expected 0", freq); else n_pass++;
      n_total++; if (freq_valid !== 1'b0) $display("FAIL reset_freq_valid: got %b expected 0", freq_valid); else n_pass++;
      n_total++; if (no_signal !== 1'b1) $display("FAIL reset_no_signal: got %b expected 1", no_signal); else n_pass++;
      n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
   endtask

   task automatic test_square();
      do_reset();
      square(1000, 2);   // only the SEEK crossing at beat 100 so far
      idle(30);
      n_total++; if (pulse_cnt !== 0) $display("FAIL square_first_cross: got %0d pulses expected 0", pulse_cnt); else n_pass++;
      n_total++; if (no_signal !== 1'b1) $display("FAIL square_no_signal_pre: got %b expected 1", no_signal); else n_pass++;
      square(1000, 2);   // crossings at beats 200 and 300, period 100 each
      idle(30);
      n_total++; if (pulse_cnt !== 2) $display("FAIL square_pulses: got %0d expected 2", pulse_cnt); else n_pass++;
      for (int i = 0; i < freq_q.size(); i++) begin
         n_total++; if (freq_q[i] !== 12'd480) $display("FAIL square_freq[%0d]: got %0d expected 480", i, freq_q[i]); else n_pass++;
      end
      n_total++; if (no_signal !== 1'b0) $display("FAIL square_no_signal_post: got %b expected 0", no_signal); else n_pass++;
   endtask

   task automatic test_latency();
      do_reset();
      beat(16'(-1000));
      beat(16'(1000));         // SEEK crossing
      beats(16'(1000), 49);
      beats(16'(-1000), 50);
      beat(16'(1000));         // crossing with period 100
      for (int k = 1; k <= 26; k++) begin
         @(negedge clk);
         sample_valid = 1'b0;
         if (k == 1) begin
            n_total++; if (busy !== 1'b1) $display("FAIL lat_busy_k1: got %b expected 1", busy); else n_pass++;
         end
         if (k == 24) begin
            n_total++; if (busy !== 1'b1) $display("FAIL lat_busy_k24: got %b expected 1", busy); else n_pass++;
            n_total++; if (freq_valid !== 1'b0) $display("FAIL lat_fv_k24: got %b expected 0", freq_valid); else n_pass++;
            n_total++; if (freq !== 12'd0) $display("FAIL lat_freq_k24: got %0d expected 0", freq); else n_pass++;
         end
         if (k == 25) begin
            n_total++; if (freq_valid !== 1'b1) $display("FAIL lat_fv_k25: got %b expected 1", freq_valid); else n_pass++;
            n_total++; if (freq !== 12'd480) $display("FAIL lat_freq_k25: got %0d expected 480", freq); else n_pass++;
            n_total++; if (busy !== 1'b0) $display("FAIL lat_busy_k25: got %b expected 0", busy); else n_pass++;
         end
         if (k == 26) begin
            n_total++; if (freq_valid !== 1'b0) $display("FAIL lat_fv_k26: got %b expected 0", freq_valid); else n_pass++;
         end
      end
   endtask

   task automatic test_sine();
      int v;
      do_reset();
      // Exact 109-sample period: rising crossings at n = 109, 218, 327, 436.
      for (int n = 0; n <= 436; n++) begin
         v = $rtoi(20000.0 * $sin(6.283185307179586 * real'(n) / 109.0));
         beat(16'(v));
      end
      idle(30);
      n_total++; if (pulse_cnt !== 3) $display("FAIL sine_pulses: got %0d expected 3", pulse_cnt); else n_pass++;
      for (int i = 0; i < freq_q.size(); i++) begin
         n_total++; if (freq_q[i] !== 12'd440) $display("FAIL sine_freq[%0d]: got %0d expected 440", i, freq_q[i]); else n_pass++;
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      // Alternating sign every clock: period 2, divides start at beats
      // 3, 29, 55, 81; every crossing in between hits a busy divider.
      for (int b = 0; b < 100; b++) begin
         if (b % 2 == 0) beat(16'(-1000));
         else            beat(16'(1000));
      end
      idle(30);
      n_total++; if (pulse_cnt !== 4) $display("FAIL b2b_pulses: got %0d expected 4", pulse_cnt); else n_pass++;
      for (int i = 0; i < freq_q.size(); i++) begin
         n_total++; if (freq_q[i] !== 12'd4095) $display("FAIL b2b_freq[%0d]: got %0d expected 4095", i, freq_q[i]); else n_pass++;
      end
   endtask

   task automatic test_timeout();
      do_reset();
      square(1000, 2);
      beat(16'd500);           // crossing, period 100
      beats(16'd500, 4094);    // one beat short of the timeout
      idle(30);
      n_total++; if (no_signal !== 1'b0) $display("FAIL to_no_signal_pre: got %b expected 0", no_signal); else n_pass++;
      n_total++; if (freq !== 12'd480) $display("FAIL to_freq_pre: got %0d expected 480", freq); else n_pass++;
      beat(16'd500);           // 4095th beat without crossing
      idle(2);
      n_total++; if (no_signal !== 1'b1) $display("FAIL to_no_signal: got %b expected 1", no_signal); else n_pass++;
      n_total++; if (freq !== 12'd0) $display("FAIL to_freq: got %0d expected 0", freq); else n_pass++;
      n_total++; if (pulse_cnt !== 1) $display("FAIL to_pulses: got %0d expected 1", pulse_cnt); else n_pass++;
      // Tone resumes: first crossing re-seeks, second one measures.
      beats(16'(-1000), 50);
      beats(16'(1000), 50);
      idle(30);
      n_total++; if (pulse_cnt !== 1) $display("FAIL to_resume_first: got %0d expected 1", pulse_cnt); else n_pass++;
      beats(16'(-1000), 50);
      beat(16'(1000));
      idle(30);
      n_total++; if (pulse_cnt !== 2) $display("FAIL to_resume_pulses: got %0d expected 2", pulse_cnt); else n_pass++;
      n_total++; if (freq !== 12'd480) $display("FAIL to_resume_freq: got %0d expected 480", freq); else n_pass++;
      n_total++; if (no_signal !== 1'b0) $display("FAIL to_resume_no_signal: got %b expected 0", no_signal); else n_pass++;
   endtask

   task automatic test_reset_mid_divide();
      do_reset();
      square(1000, 2);
      beat(16'(1000));         // first measurement, freq becomes 480
      idle(30);
      beats(16'(1000), 49);
      beats(16'(-1000), 50);
      beat(16'(1000));         // second divide starts
      for (int k = 1; k <= 9; k++) begin
         @(negedge clk);
         sample_valid = 1'b0;
      end
      rst_n = 1'b0;            // sampled at N+10
      @(negedge clk);
      rst_n = 1'b1;
      n_total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b expected 0", busy); else n_pass++;
      n_total++; if (freq !== 12'd0) $display("FAIL rst_freq: got %0d expected 0", freq); else n_pass++;
      n_total++; if (no_signal !== 1'b1) $display("FAIL rst_no_signal: got %b expected 1", no_signal); else n_pass++;
      // A crossing right after reset must only re-seek.
      beat(16'(-1000));
      beat(16'(1000));
      idle(30);
      n_total++; if (pulse_cnt !== 1) $display("FAIL rst_pulses: got %0d expected 1", pulse_cnt); else n_pass++;
      n_total++; if (no_signal !== 1'b1) $display("FAIL rst_seek_no_signal: got %b expected 1", no_signal); else n_pass++;
   endtask

   task automatic test_hyst();
      do_reset();
      square(200, 4);
      idle(30);
`ifdef OSC_FREQ_HYST_EN
      n_total++; if (pulse_cnt !== 0) $display("FAIL hyst_pulses: got %0d expected 0", pulse_cnt); else n_pass++;
      n_total++; if (no_signal !== 1'b1) $display("FAIL hyst_no_signal: got %b expected 1", no_signal); else n_pass++;
      square(2000, 3);         // clears the threshold: measures again
      idle(30);
      n_total++; if (pulse_cnt !== 1) $display("FAIL hyst_big_pulses: got %0d expected 1", pulse_cnt); else n_pass++;
      n_total++; if (freq !== 12'd480) $display("FAIL hyst_big_freq: got %0d expected 480", freq); else n_pass++;
`else
      n_total++; if (pulse_cnt !== 2) $display("FAIL nohyst_pulses: got %0d expected 2", pulse_cnt); else n_pass++;
      n_total++; if (freq !== 12'd480) $display("FAIL nohyst_freq: got %0d expected 480", freq); else n_pass++;
      n_total++; if (no_signal !== 1'b0) $display("FAIL nohyst_no_signal: got %b expected 0", no_signal); else n_pass++;
`endif
   endtask

   initial begin
      rst_n = 1'b0;
      sample_valid = 1'b0;
      sample = 16'd0;
      test_reset();
      test_square();
      test_latency();
      test_sine();
      test_back_to_back();
      test_timeout();
      test_reset_mid_divide();
      test_hyst();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/osc_freq_detect.md
# osc_freq_detect

Pitch detector for the synthesizer sample path: consumes a stream of signed 16-bit audio samples, such as the sine oscillator output or the external input, and measures the period between rising zero crossings. It converts that period to a 12-bit frequency in Hz, the same `freq` encoding the oscillators accept, using a sequential restoring divider. Used for tuner display and oscillator-lock feedback.

## Interface
- `SAMPLE_RATE`, 48000: rate of `sample_valid` beats in Hz; dividend for the divide; must be < 2^24.
- `MAX_PERIOD`, 4095: sample count with no crossing that declares loss of signal; must be < 2^16.
- `THRESH`, 1024: hysteresis arming level, positive magnitude (used only with `OSC_FREQ_HYST_EN`).
- `clk` in 1: single clock, all logic on posedge.
- `rst_n` in 1: synchronous, active-low reset.
- `sample_valid` in 1: one-cycle strobe; `sample` is valid this cycle.
- `sample` in 16: two's-complement audio sample.
- `freq` out 12: last measured frequency in Hz, saturated to 4095.
- `freq_valid` out 1: one-cycle pulse when `freq` updates.
- `no_signal` out 1: high while no valid measurement is held.
- `busy` out 1: divider running.

## Operation
- **Crossing:** a sample beat where the previous valid sample's bit 15 was 1 and the current sample's bit 15 is 0. The previous-sign register updates only on `sample_valid`.
- **Period counter:** 16 bits, increments on each `sample_valid`. On a crossing beat, `period = cnt + 1`, then `cnt` clears to 0. Cycles without `sample_valid` are ignored.
- **Control FSM states:**
  - SEEK: waiting for the first crossing. On a crossing, clear `cnt` and go to COUNT. No period is produced.
  - COUNT: each crossing latches `period` and starts the divider if it is idle. If the divider is busy, that period is discarded, but `cnt` still clears.
  - COUNT to SEEK: taken when `cnt` reaches `MAX_PERIOD - 1` on a beat with no crossing. Sets `no_signal=1` and `freq=0`, with no `freq_valid` pulse. Any running divide aborts silently.
- **Divider:**
  - 24-bit dividend `SAMPLE_RATE`, 16-bit divisor `period`.
  - Restoring algorithm, one quotient bit per clock, 24 iterations.
  - Quotient above 4095 saturates to 4095. Truncates, no rounding. Minimum period is 2, so there is no divide by zero.
- **Result:** on completion, `freq` loads the result, `freq_valid` pulses, and `no_signal` clears.
- **Reset values:** `freq=0`, `freq_valid=0`, `no_signal=1`, `busy=0`, FSM=SEEK, `cnt=0`, previous sign=0. A reset mid-divide aborts it with no pulse.

## Timing
- Crossing beat at cycle N: `period` is latched and `busy` is asserted at N+1.
- `busy` is high for cycles N+1 to N+24. `freq` and `freq_valid` update at N+25 and `busy` drops the same cycle.
- Latency from crossing beat to `freq_valid` is 25 clocks.
- If a crossing and a timeout fall on the same beat, the crossing wins.
- A crossing on the same cycle the divider completes is discarded, because `busy` is still high that cycle.
- A new crossing may start a divide at N+26 at the earliest.
- `sample_valid` spacing is unconstrained. Beats closer than 25 clocks cause dropped periods, not errors.

## Configuration
- Macro: `OSC_FREQ_HYST_EN`.
- **Defined:** an `armed` flag sets on any beat where `sample < -THRESH` (signed compare). A crossing requires `armed=1` and clears `armed`. This rejects noise chatter around zero. `armed` resets to 0.
- **Undefined:** no `armed` flag; crossings use the sign test only. `THRESH` is unused.

## Test plan
- Reset release, then 50 beats of +1000 followed by 50 beats of -1000, repeated 4 times. The first crossing produces no output. Later crossings each give `period=100` and, 25 clocks later, `freq=480` with `freq_valid` pulsing once; `no_signal` goes 1→0.
- A 440 Hz sine at 48 kHz (period 109 samples) gives `freq=440` (48000/109 truncated) on every update.
- Sign alternating every beat with back-to-back `sample_valid` strobes and hysteresis off: only one crossing in about every 25 clocks is measured, and `freq=4095` (saturated).
- A valid tone followed by a constant +500: after 4095 beats with no crossing, `no_signal=1` and `freq=0`, with no `freq_valid` pulse. The tone resuming restores measurement after two crossings.
- `rst_n` low for 1 cycle at N+10 of a divide: no `freq_valid` pulse. All outputs return to reset values at the next edge and the FSM restarts in SEEK.
- With `OSC_FREQ_HYST_EN` and a ±200 square wave at `THRESH=1024`: no crossings are counted, and `no_signal=1` after 4095 beats. With the macro undefined, the same stimulus measures normally.
